// File: rtl/ram_fill_init_pkg.sv
// Shared definitions for the RAM fill/verify initiator.
// Holds the FSM state encoding, access-interface widths and the fill rule.
// Imported by ram_fill_init and usable by anything that models its traffic.
package ram_fill_init_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int WE_W   = 4;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_WAIT = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_WAIT = 3'd4;
  localparam logic [2:0] FIN     = 3'd5;

  // Word value for a given address; the sum wraps modulo 2^32.
  function automatic logic [DATA_W-1:0] fill_word(
    input logic [DATA_W-1:0] pat,
    input logic              inc,
    input logic [ADDR_W-1:0] a
  );
    return inc ? pat + {16'h0, a} : pat;
  endfunction

endpackage

// File: rtl/ram_fill_init.sv
// Walks every RAM word writing a fill pattern, optionally re-reads and compares.
// One access per two cycles with a single-cycle responder; FIN adds one cycle.
// Waits up to TIMEOUT cycles for mem_ready per access, then flags an error.
module ram_fill_init
  import ram_fill_init_pkg::*;
#(
  parameter int NUM_WORDS = 32768,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] pattern,
  input  logic              incr_mode,
  input  logic              verify,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] error_addr,
  output logic              mem_cs,
  output logic [WE_W-1:0]   mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_ready
);

  // Terminal address compared in 16 bits so NUM_WORDS=65536 needs no extra bit.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic [7:0]        TO_LIMIT  = 8'(TIMEOUT);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        tcnt;
  logic [DATA_W-1:0] pat_q;
  logic              inc_q;
  logic              ver_q;
  logic [DATA_W-1:0] fill_val;

  assign fill_val = fill_word(pat_q, inc_q, addr);

  // Access strobes are decoded from state so they drop the cycle after reset.
  always_comb begin
    busy           = (state != IDLE) && (state != FIN);
    mem_cs         = (state == WR_REQ) || (state == RD_REQ);
    mem_we         = (state == WR_REQ) ? 4'hf : 4'h0;
    mem_address    = addr;
    mem_write_data = (state == WR_REQ) ? fill_val : '0;
  end

  // Main sequencer: address walk, timeout counting and read-back compare.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= '0;
      tcnt       <= '0;
      pat_q      <= '0;
      inc_q      <= 1'b0;
      ver_q      <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      error_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pat_q      <= pattern;
            inc_q      <= incr_mode;
            ver_q      <= verify;
            done       <= 1'b0;
            error      <= 1'b0;
            error_addr <= '0;
            addr       <= '0;
            state      <= WR_REQ;
          end
        end
        WR_REQ: begin
          tcnt  <= '0;
          state <= WR_WAIT;
        end
        WR_WAIT: begin
          if (mem_ready) begin
            if (addr == LAST_ADDR) begin
              if (ver_q) begin
                addr  <= '0;
                state <= RD_REQ;
              end else begin
                state <= FIN;
              end
            end else begin
              addr  <= addr + 1'b1;
              state <= WR_REQ;
            end
          end else if (tcnt == TO_LIMIT) begin
            error      <= 1'b1;
            error_addr <= addr;
            state      <= FIN;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RD_REQ: begin
          tcnt  <= '0;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (mem_ready) begin
            if (mem_read_data != fill_val) begin
              error      <= 1'b1;
              error_addr <= addr;
              state      <= FIN;
            end else if (addr == LAST_ADDR) begin
              state <= FIN;
            end else begin
              addr  <= addr + 1'b1;
              state <= RD_REQ;
            end
          end else if (tcnt == TO_LIMIT) begin
            error      <= 1'b1;
            error_addr <= addr;
            state      <= FIN;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_fill_init.sv
// Bench for ram_fill_init with an 8-word single-cycle RAM model.
// Fault knobs: stuck bit on word 5 reads, withheld ready on a write address.
// Expected words come from the fill rule; durations from the word count.
module tb_ram_fill_init;

  localparam int NW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] pattern;
  logic        incr_mode;
  logic        verify;
  logic        busy, done, error;
  logic [15:0] error_addr;
  logic        mem_cs;
  logic [3:0]  mem_we;
  logic [15:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_fill_init #(.NUM_WORDS(NW), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .incr_mode(incr_mode), .verify(verify), .busy(busy), .done(done),
    .error(error), .error_addr(error_addr), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready)
  );

  // RAM model
  logic [31:0] ram [0:NW-1];
  logic        stuck_en = 1'b0;
  logic        hold_en  = 1'b0;
  logic [15:0] hold_addr = 16'd0;

  always @(posedge clk) begin
    mem_ready <= 1'b0;
    if (mem_cs && !(hold_en && mem_we != 4'h0 && mem_address == hold_addr)) begin
      mem_ready <= 1'b1;
      if (mem_we == 4'hf) ram[mem_address[2:0]] <= mem_write_data;
      mem_read_data <= ram[mem_address[2:0]] |
                       {31'b0, (stuck_en && mem_address == 16'd5)};
    end
  end

  // Bus monitor
  int   cs_cnt = 0;
  int   consec_cnt = 0;
  int   rd_hi_cnt = 0;
  logic prev_cs = 1'b0;

  always @(negedge clk) begin
    if (mem_cs) begin
      cs_cnt++;
      if (prev_cs) consec_cnt++;
      if (mem_we == 4'h0 && mem_address > 16'd5) rd_hi_cnt++;
    end
    prev_cs = mem_cs;
  end

  function automatic logic [31:0] ref_fill(input logic [31:0] p, input logic inc, input int a);
    logic [63:0] s;
    s = inc ? ({32'h0, p} + 64'(a)) : {32'h0, p};
    return s[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] p, input logic inc, input logic ver,
                        input int inject_at, output int cyc,
                        output logic fc, output logic [15:0] fa);
    @(negedge clk);
    pattern = p; incr_mode = inc; verify = ver; start = 1'b1;
    cyc = 0; fc = 1'b0; fa = 16'hffff;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin fc = mem_cs; fa = mem_address; end
      start = 1'b0;
      if (cyc == inject_at) begin
        start = 1'b1; pattern = ~p; incr_mode = ~inc; verify = ~ver;
      end
      if (done) break;
    end
    chk("op_completes", {31'b0, done}, 32'd1);
  endtask

  task automatic chk_ram(input string tag, input logic [31:0] p, input logic inc);
    for (int a = 0; a < NW; a++) chk(tag, ram[a], ref_fill(p, inc, a));
  endtask

  initial begin
    int          cyc;
    logic        fc;
    logic [15:0] fa;
    int          cs0, cons0, rdh0;
    logic [31:0] rp;
    logic        ri, rv;

    reset = 1'b1; start = 1'b0; pattern = '0; incr_mode = 1'b0; verify = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    chk("rst_cs", {31'b0, mem_cs}, 32'd0);
    chk("rst_we", {28'b0, mem_we}, 32'd0);
    chk("rst_addr", {16'b0, mem_address}, 32'd0);
    chk("rst_wdata", mem_write_data, 32'd0);
    chk("rst_err_addr", {16'b0, error_addr}, 32'd0);
    reset = 1'b0;

    // Plain fill, no verify
    cons0 = consec_cnt;
    run_op(32'hA5A5_0000, 1'b0, 1'b0, 0, cyc, fc, fa);
    chk("t1_cycles", 32'(cyc), 32'(2*NW+2));
    chk("t1_error", {31'b0, error}, 32'd0);
    chk("t1_first_cs", {31'b0, fc}, 32'd1);
    chk_ram("t1_word", 32'hA5A5_0000, 1'b0);
    chk("t1_no_back_to_back_cs", 32'(consec_cnt - cons0), 32'd0);

    // Incrementing fill with verify, wraps past 2^32
    run_op(32'hFFFF_FFFE, 1'b1, 1'b1, 0, cyc, fc, fa);
    chk("t2_cycles", 32'(cyc), 32'(4*NW+2));
    chk("t2_error", {31'b0, error}, 32'd0);
    chk("t2_word0", ram[0], 32'hFFFF_FFFE);
    chk("t2_word1", ram[1], 32'hFFFF_FFFF);
    chk("t2_word2_wrap", ram[2], 32'h0000_0000);
    chk_ram("t2_word", 32'hFFFF_FFFE, 1'b1);
    chk("t2_no_back_to_back_cs", 32'(consec_cnt - cons0), 32'd0);

    // Read-back mismatch on word 5
    @(negedge clk); stuck_en = 1'b1;
    rdh0 = rd_hi_cnt;
    run_op(32'h0, 1'b0, 1'b1, 0, cyc, fc, fa);
    chk("t3_error", {31'b0, error}, 32'd1);
    chk("t3_err_addr", {16'b0, error_addr}, 32'd5);
    chk("t3_done", {31'b0, done}, 32'd1);
    chk("t3_no_reads_after_5", 32'(rd_hi_cnt - rdh0), 32'd0);
    stuck_en = 1'b0;

    // Withheld ready on write to address 3
    hold_en = 1'b1; hold_addr = 16'd3;
    cs0 = cs_cnt;
    run_op(32'h1234_5678, 1'b0, 1'b1, 0, cyc, fc, fa);
    chk("t4_error", {31'b0, error}, 32'd1);
    chk("t4_err_addr", {16'b0, error_addr}, 32'd3);
    chk("t4_cycles", 32'(cyc), 32'd14);
    repeat (10) @(negedge clk);
    chk("t4_cs_count", 32'(cs_cnt - cs0), 32'd4);
    hold_en = 1'b0;

    // Reset during RD_WAIT of address 2
    pattern = $urandom; incr_mode = 1'b1; verify = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(mem_cs && mem_we == 4'h0 && mem_address == 16'd2) && cyc < 200) begin
      @(negedge clk); cyc++;
    end
    chk("t5_reached_rd2", {31'b0, mem_cs}, 32'd1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_cs", {31'b0, mem_cs}, 32'd0);
    chk("t5_done", {31'b0, done}, 32'd0);
    chk("t5_error", {31'b0, error}, 32'd0);
    rp = $urandom;
    run_op(rp, 1'b1, 1'b0, 0, cyc, fc, fa);
    chk("t5_restart_cs", {31'b0, fc}, 32'd1);
    chk("t5_restart_addr0", {16'b0, fa}, 32'd0);
    chk("t5_cycles", 32'(cyc), 32'(2*NW+2));
    chk_ram("t5_word", rp, 1'b1);

    // Start while busy is ignored
    rp = $urandom;
    run_op(rp, 1'b0, 1'b0, 7, cyc, fc, fa);
    chk("t6_cycles", 32'(cyc), 32'(2*NW+2));
    chk_ram("t6_word", rp, 1'b0);

    // Random clean runs
    for (int k = 0; k < 4; k++) begin
      rp = $urandom; ri = 1'($urandom); rv = 1'($urandom);
      run_op(rp, ri, rv, 0, cyc, fc, fa);
      chk("rnd_cycles", 32'(cyc), rv ? 32'(4*NW+2) : 32'(2*NW+2));
      chk("rnd_error", {31'b0, error}, 32'd0);
      chk_ram("rnd_word", rp, ri);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_fill_init.md
Name: ram_fill_init

Overview:
- Bus initiator that drives the scrambled-RAM access interface: cs, we, address, write_data, read_data, ready.
- On a start pulse it writes a fill pattern to every RAM word.
- It can then re-read every word and compare it, reporting done, error and the first failing address.
- It sits between boot control and the RAM mux, and clears or initialises RAM before the CPU is released.

Parameters:
- NUM_WORDS, 32768, number of 32-bit words to walk (address 0 .. NUM_WORDS-1); legal range 2 .. 65536.
- TIMEOUT, 15, maximum cycles to wait for mem_ready after an access before declaring error; legal range 1 .. 255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins an operation when idle
- pattern  in  32  fill value, sampled at start
- incr_mode  in  1  sampled at start; 1: word = pattern + address, 0: word = pattern
- verify  in  1  sampled at start; 1: perform a read-back pass after the write pass
- busy  out  1  high while an operation runs
- done  out  1  sticky; set at operation end, cleared by the next accepted start or reset
- error  out  1  sticky; mismatch or timeout; cleared like done
- error_addr  out  16  address of the first failure; 0 if none
- mem_cs  out  1  access strobe to RAM
- mem_we  out  4  byte write enables
- mem_address  out  16  word address
- mem_write_data  out  32  write data
- mem_read_data  in  32  read data, valid in the cycle mem_ready=1
- mem_ready  in  1  access complete

Behaviour:
- Reset is synchronous and active-high on clk.
  - Reset values: state IDLE; busy, done, error, mem_cs = 0; mem_we = 0; mem_address, mem_write_data, error_addr = 0.
  - Reset mid-operation aborts the operation. mem_cs is 0 from the cycle after reset is sampled. No partial-state output remains.
- Access protocol:
  - mem_cs is high for exactly one cycle per access. mem_we, mem_address and mem_write_data are stable in that cycle.
  - The block then waits with mem_cs=0 for mem_ready=1.
  - A single-cycle responder gives 2 cycles per word.
  - mem_ready seen in the REQ cycle itself is ignored.
- States:
  - IDLE: busy=0. If start=1, latch pattern/incr_mode/verify, clear done/error/error_addr, set addr=0, and go to WR_REQ. Start is ignored when not in IDLE.
  - WR_REQ: mem_cs=1, mem_we=4'hf, mem_address=addr, mem_write_data=fill(addr). Go to WR_WAIT.
  - WR_WAIT: mem_cs=0, mem_we=0. Transitions:
    - On mem_ready: if addr==NUM_WORDS-1, go to RD_REQ with addr=0 when verify=1, else go to FIN. Otherwise addr+1 and go to WR_REQ.
    - If the timeout counter reaches TIMEOUT without mem_ready: error=1, error_addr=addr, go to FIN.
  - RD_REQ: mem_cs=1, mem_we=0, mem_address=addr. Go to RD_WAIT.
  - RD_WAIT: on mem_ready, compare mem_read_data with fill(addr).
    - Mismatch: error=1, error_addr=addr, go to FIN (stop at first failure).
    - Match on last address: go to FIN.
    - Match otherwise: addr+1 and go to RD_REQ.
    - Timeout is handled as in WR_WAIT.
  - FIN: done=1, busy=0, go to IDLE. A start in FIN is ignored; the next start is accepted in IDLE.
- Arithmetic:
  - fill(addr) = incr_mode ? pattern + {16'h0, addr} : pattern, taken modulo 2^32 (wraps).
  - addr is 16 bits and never exceeds NUM_WORDS-1. The terminal comparison uses NUM_WORDS-1, so NUM_WORDS=65536 needs no 17th bit.
- Timeout counter:
  - 8 bits, cleared in every REQ state, incremented each WAIT cycle without mem_ready.
  - Timeout fires when count==TIMEOUT.
  - If mem_ready and the timeout coincide, mem_ready wins.
- busy=1 in all states except IDLE and FIN.
- Total duration with a 1-cycle responder:
  - 2*NUM_WORDS+2 cycles without verify.
  - 4*NUM_WORDS+2 cycles with verify.

Decomposition:
- Shared package:
  - state encoding localparams: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, FIN;
  - the access-interface widths: address 16, data 32, we 4.
- Sub-module: none. Address counter, timeout counter and comparator stay in a single FSM module.

Test Plan:
- Bench setup: NUM_WORDS=8 and a behavioural 1-cycle-ready RAM.
- Write-only fill: start, pattern=32'hA5A5_0000, incr_mode=0, verify=0.
  - All 8 words read 32'hA5A5_0000 afterwards.
  - done=1, error=0 after exactly 18 cycles.
  - mem_cs is never high for two consecutive cycles.
- Incrementing fill with verify: start, pattern=32'hFFFF_FFFE, incr_mode=1, verify=1.
  - Word 0 = 32'hFFFF_FFFE, word 1 = 32'hFFFF_FFFF, word 2 = 32'h0000_0000 (wrap).
  - done after 34 cycles, error=0.
- Mismatch: model forces bit 0 of word 5 stuck at 1, pattern=0, incr_mode=0, verify=1.
  - error=1, error_addr=5, done=1.
  - No read is issued for addresses 6-7.
- Timeout: model withholds mem_ready on the write to address 3, TIMEOUT=4.
  - error=1, error_addr=3, done=1 after 4 wait cycles.
  - No further mem_cs.
- Reset and start handling:
  - Assert reset during RD_WAIT of address 2: next cycle busy=0, mem_cs=0, done=0, error=0.
  - A subsequent start restarts from address 0.
  - A start pulse while busy is ignored: latched pattern unchanged, and the operation finishes with the original cycle count.
